// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT butterfly address sequencer with registered outputs.
// Optional bit-reversed input-load phase enabled by defining FFT_AG_BITREV_LOAD_EN.
module fft_addr_gen #(
  parameter int LOG2N = 5,
  parameter int STG_W = 3
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             valid,
  output logic             load_vld,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic [STG_W-1:0] stage,
  output logic             done
);

  // Handshake: valid/load_vld high means the registered addresses describe an
  // operation issued this cycle; a stalled edge re-shows the pending one with valid low.
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [LOG2N-1:0] ONE       = LOG2N'(1);
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(LOG2N - 1);

  state_t           state_q, state_d;
  logic [STG_W-1:0] s_q, s_d;
  logic [LOG2N-2:0] j_q, j_d;
  logic [LOG2N-1:0] k_q, k_d;
  logic             fin_q, fin_d;

  logic             busy_d, valid_d, load_d, done_d;
  logic [LOG2N-1:0] a_d, b_d;
  logic [LOG2N-2:0] tw_d;
  logic [STG_W-1:0] stage_d;
  logic             do_run, do_load, hold;

  logic [LOG2N-1:0] half, mask, jx, pos, bf_a, bf_b, tw_full;
  logic [LOG2N-2:0] bf_tw;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // grp*2*half is j with its low s bits cleared, shifted up by one.
  always_comb begin
    half    = ONE << s_q;
    mask    = half - ONE;
    jx      = {1'b0, j_q};
    pos     = jx & mask;
    bf_a    = ((jx & ~mask) << 1) | pos;
    bf_b    = bf_a + half;
    tw_full = pos << (LAST_STG - s_q);
    bf_tw   = tw_full[LOG2N-2:0];
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    k_d     = k_q;
    fin_d   = fin_q;
    valid_d = 1'b0;
    load_d  = 1'b0;
    done_d  = 1'b0;
    a_d     = '0;
    b_d     = '0;
    tw_d    = '0;
    stage_d = '0;
    do_run  = 1'b0;
    do_load = 1'b0;
    hold    = stall;

    case (state_q)
      IDLE: begin
        hold = 1'b0;
        if (start) begin
`ifdef FFT_AG_BITREV_LOAD_EN
          state_d = LOAD;
          do_load = 1'b1;
`else
          state_d = RUN;
          do_run  = 1'b1;
`endif
        end
      end
      LOAD: begin
        if (fin_q) begin
          state_d = RUN;
          fin_d   = 1'b0;
          do_run  = 1'b1;
        end else begin
          do_load = 1'b1;
        end
      end
      RUN: begin
        if (fin_q) begin
          state_d = DONE;
          fin_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          do_run = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      a_d = bitrev(k_q);
`ifdef FFT_AG_BITREV_LOAD_EN
      load_d = !hold;
`endif
      if (!hold) begin
        k_d = k_q + ONE;
        if (k_q == '1) fin_d = 1'b1;
      end
    end

    if (do_run) begin
      a_d     = bf_a;
      b_d     = bf_b;
      tw_d    = bf_tw;
      stage_d = s_q;
      valid_d = !hold;
      if (!hold) begin
        if (j_q == '1) begin
          j_d = '0;
          if (s_q == LAST_STG) begin
            s_d   = '0;
            fin_d = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      fin_q    <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      load_vld <= 1'b0;
      done     <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_addr  <= '0;
      stage    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      j_q      <= j_d;
      k_q      <= k_d;
      fin_q    <= fin_d;
      busy     <= busy_d;
      valid    <= valid_d;
      load_vld <= load_d;
      done     <= done_d;
      addr_a   <= a_d;
      addr_b   <= b_d;
      tw_addr  <= tw_d;
      stage    <= stage_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen: arithmetic reference sequence, random stalls,
// directed stall, abort and ignored-start scenarios.
module tb_fft_addr_gen;

  localparam int LOG2N = 5;
  localparam int STG_W = 3;
  localparam int N     = 1 << LOG2N;
  localparam int NBF   = (N / 2) * LOG2N;
  localparam int W     = 1 + LOG2N + LOG2N + (LOG2N - 1) + STG_W;

  logic             clk = 1'b0;
  logic             sclr_n, start, stall;
  logic             busy, valid, load_vld, done;
  logic [LOG2N-1:0] addr_a, addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic [STG_W-1:0] stage;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int run_idx;

  always #5 clk = ~clk;

  fft_addr_gen #(.LOG2N(LOG2N), .STG_W(STG_W)) dut (
    .clk(clk), .sclr_n(sclr_n), .start(start), .stall(stall),
    .busy(busy), .valid(valid), .load_vld(load_vld),
    .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
    .stage(stage), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev_ref(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Expected issue order: optional load addresses, then every (s,j) butterfly.
  task automatic fill_q();
    int a, b, tw, half, pos, grp;
    exp_q.delete();
`ifdef FFT_AG_BITREV_LOAD_EN
    for (int k = 0; k < N; k++)
      exp_q.push_back({1'b1, LOG2N'(bitrev_ref(k)), LOG2N'(0), (LOG2N-1)'(0), STG_W'(0)});
`endif
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        half = 2 ** s;
        pos  = j % half;
        grp  = j / half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = pos * (2 ** (LOG2N - 1 - s));
        exp_q.push_back({1'b0, LOG2N'(a), LOG2N'(b), (LOG2N-1)'(tw), STG_W'(s)});
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {valid, load_vld, done}, 0);
    check({tag, "_addr"}, {addr_a, addr_b, tw_addr, stage}, 0);
  endtask

  // Outputs after an edge where stall was st: the pending entry, issued only if not stalled.
  task automatic observe(input logic st);
    logic [W-1:0] f;
    logic [1:0]   ef;
    f  = exp_q[0];
    ef = f[W-1] ? {1'b0, !st} : {!st, 1'b0};
    check("flags", {valid, load_vld}, ef);
    check("addr", {addr_a, addr_b, tw_addr, stage}, f[W-2:0]);
    check("busy_run", {busy, done}, 2'b10);
    if (!st) begin
      void'(exp_q.pop_front());
      if (!f[W-1]) begin
        case (run_idx)
          0:  check("bf_0_0", {addr_a, addr_b, tw_addr}, {5'd0, 5'd1, 4'd0});
          19: check("bf_1_3", {addr_a, addr_b, tw_addr}, {5'd5, 5'd7, 4'd8});
          20: check("bf_1_4", {addr_a, addr_b, tw_addr}, {5'd8, 5'd10, 4'd0});
          37: check("bf_2_5", {addr_a, addr_b, tw_addr}, {5'd9, 5'd13, 4'd4});
          79: check("bf_4_15", {addr_a, addr_b, tw_addr}, {5'd15, 5'd31, 4'd15});
          default: ;
        endcase
        run_idx++;
      end
    end
  endtask

  // mode: 0 no stall, 1 random stall, 2 three stalls at butterfly 19, 3 start pokes while busy
  task automatic xfer(input int mode, input int abort_at);
    logic st;
    int   cyc = 0;
    int   stall_cnt = 0;
    fill_q();
    run_idx = 0;
    start = 1'b1;
    stall = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    observe(1'b0);
    while (exp_q.size() > 0) begin
      if (abort_at >= 0 && run_idx == abort_at) begin
        sclr_n = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        tick();
        sclr_n = 1'b1;
        check_zero("abort");
        repeat (5) begin
          tick();
          check("abort_idle", {busy, done, valid}, 0);
        end
        return;
      end
      st = 1'b0;
      case (mode)
        1: st = ($urandom_range(0, 3) == 0);
        2: if (run_idx == 19 && !exp_q[0][W-1] && stall_cnt < 3) begin
             st = 1'b1;
             stall_cnt++;
           end
        3: start = 1'($urandom_range(0, 1));
        default: ;
      endcase
      stall = st;
      tick();
      observe(st);
      cyc++;
      if (cyc > 600) begin
        check("timeout", 1, 0);
        exp_q.delete();
      end
    end
    stall = 1'b0;
    start = (mode == 3);
    tick();
    check("done_pulse", {done, busy, valid, load_vld}, 4'b1100);
    start = (mode == 3);
    stall = 1'($urandom_range(0, 1));
    tick();
    check("after_done", {done, busy, valid}, 0);
    start = 1'b0;
    stall = 1'b0;
    tick();
    check("idle_stays", {done, busy}, 0);
    check("n_bf", run_idx, NBF);
    if (mode == 2) check("stall_cnt", stall_cnt, 3);
  endtask

  initial begin
    sclr_n = 1'b0;
    start  = 1'b1;
    stall  = 1'b1;
    tick();
    tick();
    check_zero("reset");
    sclr_n = 1'b1;
    start  = 1'b0;
    stall  = 1'b0;
    tick();
    check_zero("idle");

    xfer(0, -1);
    xfer(2, -1);
    xfer(1, -1);
    xfer(1, 40);
    xfer(0, -1);
    xfer(3, -1);
    repeat (3) xfer(1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
